// File: rtl/cheri_lsu_bg_arb.sv
// LSU request-port arbiter between the core pipeline and the merged background-engine port.
// Tracks the owner of each outstanding transaction so responses route back to the right requester.
module cheri_lsu_bg_arb #(
  parameter int unsigned OutstDepth  = 2,
  parameter int unsigned BgStarveMax = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic        core_is_cap_i,
  input  logic [31:0] core_addr_i,
  input  logic [32:0] core_wdata_i,
  output logic        core_req_done_o,
  output logic        core_resp_valid_o,

  input  logic        bg_req_i,
  input  logic        bg_we_i,
  input  logic        bg_is_cap_i,
  input  logic [31:0] bg_addr_i,
  input  logic [32:0] bg_wdata_i,
  output logic        bg_req_done_o,
  output logic        bg_resp_valid_o,
  output logic        bg_resp_err_o,
  output logic        bg_resp_is_wr_o,

  output logic        lsu_req_o,
  output logic        lsu_we_o,
  output logic        lsu_is_cap_o,
  output logic [31:0] lsu_addr_o,
  output logic [32:0] lsu_wdata_o,
  input  logic        lsu_req_done_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_last_i,
  input  logic        lsu_resp_err_i,

  output logic        snoop_req_o,
  output logic        snoop_req_done_o,
  output logic        snoop_we_o,
  output logic        snoop_is_cap_o,
  output logic [31:0] snoop_addr_o,
  output logic        fifo_full_o
);

  localparam int unsigned PtrW = (OutstDepth > 1) ? $clog2(OutstDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = 4;

  typedef enum logic {
    OwnCore = 1'b0,
    OwnBg   = 1'b1
  } owner_e;

  logic                  lock_q, lock_d;
  owner_e                lock_owner_q, lock_owner_d;
  logic [StW-1:0]        starve_q, starve_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OutstDepth-1:0] fifo_bg_q, fifo_we_q;

  logic   en, fifo_full, fifo_empty, starve_force;
  owner_e owner;
  logic   win_req, grant_done, core_done, bg_done, push, pop, resp_ok;
  logic   head_bg, head_we;

  // Outputs are forced low while reset is held, including the pass-through paths.
  assign en         = rst_ni;
  assign fifo_full  = (cnt_q == CntW'(OutstDepth));
  assign fifo_empty = (cnt_q == '0);

  assign starve_force = (starve_q >= StW'(BgStarveMax)) && bg_req_i;

  always_comb begin
    owner = OwnCore;
    if (lock_q) begin
      owner = lock_owner_q;
    end else if (bg_req_i && (!core_req_i || starve_force)) begin
      owner = OwnBg;
    end
  end

  assign win_req = (owner == OwnBg) ? bg_req_i : core_req_i;

  assign lsu_req_o    = en & win_req & ~fifo_full;
  assign lsu_we_o     = en & ((owner == OwnBg) ? bg_we_i : core_we_i);
  assign lsu_is_cap_o = en & ((owner == OwnBg) ? bg_is_cap_i : core_is_cap_i);
  assign lsu_addr_o   = en ? ((owner == OwnBg) ? bg_addr_i : core_addr_i) : 32'd0;
  assign lsu_wdata_o  = en ? ((owner == OwnBg) ? bg_wdata_i : core_wdata_i) : 33'd0;

  assign grant_done      = lsu_req_o & lsu_req_done_i;
  assign core_done       = grant_done & (owner == OwnCore);
  assign bg_done         = grant_done & (owner == OwnBg);
  assign core_req_done_o = core_done;
  assign bg_req_done_o   = bg_done;

  // Response routing follows the oldest outstanding owner tag.
  assign head_bg = fifo_bg_q[rptr_q];
  assign head_we = fifo_we_q[rptr_q];
  assign resp_ok = en & lsu_resp_valid_i & ~fifo_empty;
  assign push    = grant_done;
  assign pop     = resp_ok & lsu_resp_last_i;

  assign core_resp_valid_o = resp_ok & ~head_bg;
  assign bg_resp_valid_o   = resp_ok & head_bg;
  assign bg_resp_err_o     = bg_resp_valid_o & lsu_resp_err_i;
  assign bg_resp_is_wr_o   = bg_resp_valid_o & head_we;

  assign snoop_req_o      = en & core_req_i;
  assign snoop_we_o       = en & core_we_i;
  assign snoop_is_cap_o   = en & core_is_cap_i;
  assign snoop_addr_o     = en ? core_addr_i : 32'd0;
  assign snoop_req_done_o = core_done;
  assign fifo_full_o      = en & fifo_full;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    starve_d     = starve_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;

    if (grant_done) begin
      lock_d = 1'b0;
    end else if (lsu_req_o && !lock_q) begin
      lock_d       = 1'b1;
      lock_owner_d = owner;
    end

    if (bg_done || !bg_req_i) begin
      starve_d = '0;
    end else if (core_done && (starve_q < StW'(BgStarveMax))) begin
      starve_d = starve_q + StW'(1);
    end

    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OwnCore;
      starve_q     <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_bg_q    <= '0;
      fifo_we_q    <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      if (push) begin
        fifo_bg_q[wptr_q] <= (owner == OwnBg);
        fifo_we_q[wptr_q] <= lsu_we_o;
      end
    end
  end

  // A response with nothing outstanding has no owner and is dropped.
  resp_without_owner_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(lsu_resp_valid_i && fifo_empty));

endmodule

// File: tb/tb_cheri_lsu_bg_arb.sv
// Directed self-checking bench for cheri_lsu_bg_arb with default parameters.
module tb_cheri_lsu_bg_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i, core_is_cap_i;
  logic [31:0] core_addr_i;
  logic [32:0] core_wdata_i;
  logic        core_req_done_o, core_resp_valid_o;
  logic        bg_req_i, bg_we_i, bg_is_cap_i;
  logic [31:0] bg_addr_i;
  logic [32:0] bg_wdata_i;
  logic        bg_req_done_o, bg_resp_valid_o, bg_resp_err_o, bg_resp_is_wr_o;
  logic        lsu_req_o, lsu_we_o, lsu_is_cap_o;
  logic [31:0] lsu_addr_o;
  logic [32:0] lsu_wdata_o;
  logic        lsu_req_done_i, lsu_resp_valid_i, lsu_resp_last_i, lsu_resp_err_i;
  logic        snoop_req_o, snoop_req_done_o, snoop_we_o, snoop_is_cap_o;
  logic [31:0] snoop_addr_o;
  logic        fifo_full_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  cheri_lsu_bg_arb #(.OutstDepth(2), .BgStarveMax(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_is_cap_i(core_is_cap_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_req_done_o(core_req_done_o), .core_resp_valid_o(core_resp_valid_o),
    .bg_req_i(bg_req_i), .bg_we_i(bg_we_i), .bg_is_cap_i(bg_is_cap_i),
    .bg_addr_i(bg_addr_i), .bg_wdata_i(bg_wdata_i),
    .bg_req_done_o(bg_req_done_o), .bg_resp_valid_o(bg_resp_valid_o),
    .bg_resp_err_o(bg_resp_err_o), .bg_resp_is_wr_o(bg_resp_is_wr_o),
    .lsu_req_o(lsu_req_o), .lsu_we_o(lsu_we_o), .lsu_is_cap_o(lsu_is_cap_o),
    .lsu_addr_o(lsu_addr_o), .lsu_wdata_o(lsu_wdata_o),
    .lsu_req_done_i(lsu_req_done_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_last_i(lsu_resp_last_i), .lsu_resp_err_i(lsu_resp_err_i),
    .snoop_req_o(snoop_req_o), .snoop_req_done_o(snoop_req_done_o),
    .snoop_we_o(snoop_we_o), .snoop_is_cap_o(snoop_is_cap_o),
    .snoop_addr_o(snoop_addr_o), .fifo_full_o(fifo_full_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    core_req_i = 1'b1; core_we_i = 1'b1; core_is_cap_i = 1'b0;
    core_addr_i = 32'h0000_1234; core_wdata_i = 33'd0;
    bg_req_i = 1'b1; bg_we_i = 1'b0; bg_is_cap_i = 1'b0;
    bg_addr_i = 32'h0000_5678; bg_wdata_i = 33'd0;
    lsu_req_done_i = 1'b0; lsu_resp_valid_i = 1'b0;
    lsu_resp_last_i = 1'b0; lsu_resp_err_i = 1'b0;

    // reset: every output low even with requests pending
    #12;
    chk("rst_lsu_req", 64'(lsu_req_o), 64'd0);
    chk("rst_lsu_addr", 64'(lsu_addr_o), 64'd0);
    chk("rst_lsu_we", 64'(lsu_we_o), 64'd0);
    chk("rst_snoop_req", 64'(snoop_req_o), 64'd0);
    chk("rst_fifo_full", 64'(fifo_full_o), 64'd0);
    core_req_i = 1'b0; core_we_i = 1'b0; bg_req_i = 1'b0;
    core_addr_i = 32'd0; bg_addr_i = 32'd0;
    tick();
    rst_ni = 1'b1;

    // core-only read
    core_addr_i = 32'h8000_0010; core_req_i = 1'b1; #1;
    chk("core_lsu_req", 64'(lsu_req_o), 64'd1);
    chk("core_lsu_addr", 64'(lsu_addr_o), 64'h8000_0010);
    chk("core_done_early", 64'(core_req_done_o), 64'd0);
    chk("core_snoop_addr", 64'(snoop_addr_o), 64'h8000_0010);
    tick();
    lsu_req_done_i = 1'b1; #1;
    chk("core_done", 64'(core_req_done_o), 64'd1);
    chk("core_done_bg", 64'(bg_req_done_o), 64'd0);
    chk("core_snoop_done", 64'(snoop_req_done_o), 64'd1);
    tick();
    core_req_i = 1'b0; lsu_req_done_i = 1'b0;
    lsu_resp_valid_i = 1'b1; lsu_resp_last_i = 1'b1; #1;
    chk("core_resp", 64'(core_resp_valid_o), 64'd1);
    chk("core_resp_bg", 64'(bg_resp_valid_o), 64'd0);
    tick();
    lsu_resp_valid_i = 1'b0; lsu_resp_last_i = 1'b0;

    // bg write held locked for 3 cycles while the core arrives
    bg_req_i = 1'b1; bg_we_i = 1'b1; bg_addr_i = 32'h2000_0040;
    bg_wdata_i = 33'h1_DEAD_BEEF; #1;
    chk("bg_lsu_addr", 64'(lsu_addr_o), 64'h2000_0040);
    chk("bg_lsu_we", 64'(lsu_we_o), 64'd1);
    chk("bg_lsu_wdata", 64'(lsu_wdata_o), 64'h1_DEAD_BEEF);
    tick();
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h8000_0100; #1;
    chk("lock_c1_addr", 64'(lsu_addr_o), 64'h2000_0040);
    chk("lock_c1_bgdone", 64'(bg_req_done_o), 64'd0);
    tick();
    chk("lock_c2_addr", 64'(lsu_addr_o), 64'h2000_0040);
    tick();
    lsu_req_done_i = 1'b1; #1;
    chk("lock_done_bg", 64'(bg_req_done_o), 64'd1);
    chk("lock_done_core", 64'(core_req_done_o), 64'd0);
    chk("lock_done_addr", 64'(lsu_addr_o), 64'h2000_0040);
    tick();
    bg_req_i = 1'b0; #1;
    chk("switch_addr", 64'(lsu_addr_o), 64'h8000_0100);
    chk("switch_core_done", 64'(core_req_done_o), 64'd1);
    tick();

    // outstanding limit: two pending, core still requesting
    lsu_req_done_i = 1'b0; #1;
    chk("full_flag", 64'(fifo_full_o), 64'd1);
    chk("full_no_req", 64'(lsu_req_o), 64'd0);
    lsu_resp_valid_i = 1'b1; lsu_resp_last_i = 1'b1; #1;
    chk("full_resp_bg", 64'(bg_resp_valid_o), 64'd1);
    chk("full_resp_is_wr", 64'(bg_resp_is_wr_o), 64'd1);
    chk("full_resp_err", 64'(bg_resp_err_o), 64'd0);
    chk("full_resp_core", 64'(core_resp_valid_o), 64'd0);
    chk("full_still_blocked", 64'(lsu_req_o), 64'd0);
    tick();
    lsu_resp_valid_i = 1'b0; #1;
    chk("reassert_req", 64'(lsu_req_o), 64'd1);
    chk("reassert_not_full", 64'(fifo_full_o), 64'd0);
    lsu_req_done_i = 1'b1; lsu_resp_valid_i = 1'b1; #1;
    chk("pushpop_core_resp", 64'(core_resp_valid_o), 64'd1);
    chk("pushpop_core_done", 64'(core_req_done_o), 64'd1);
    tick();
    core_req_i = 1'b0; lsu_req_done_i = 1'b0; #1;
    chk("pushpop_not_full", 64'(fifo_full_o), 64'd0);
    chk("drain_core_resp", 64'(core_resp_valid_o), 64'd1);
    tick();
    lsu_resp_valid_i = 1'b0; lsu_resp_last_i = 1'b0;

    // response ordering: core then bg read, second response errored
    core_req_i = 1'b1; core_addr_i = 32'h8000_0200; lsu_req_done_i = 1'b1; #1;
    chk("ord_core_done", 64'(core_req_done_o), 64'd1);
    tick();
    core_req_i = 1'b0; bg_req_i = 1'b1; bg_we_i = 1'b0; bg_addr_i = 32'h2000_0080; #1;
    chk("ord_bg_done", 64'(bg_req_done_o), 64'd1);
    tick();
    bg_req_i = 1'b0; lsu_req_done_i = 1'b0;
    lsu_resp_valid_i = 1'b1; lsu_resp_last_i = 1'b1; #1;
    chk("ord_r1_core", 64'(core_resp_valid_o), 64'd1);
    chk("ord_r1_bg", 64'(bg_resp_valid_o), 64'd0);
    tick();
    lsu_resp_err_i = 1'b1; #1;
    chk("ord_r2_bg", 64'(bg_resp_valid_o), 64'd1);
    chk("ord_r2_err", 64'(bg_resp_err_o), 64'd1);
    chk("ord_r2_is_wr", 64'(bg_resp_is_wr_o), 64'd0);
    chk("ord_r2_core", 64'(core_resp_valid_o), 64'd0);
    tick();
    lsu_resp_valid_i = 1'b0; lsu_resp_last_i = 1'b0; lsu_resp_err_i = 1'b0;

    // starvation: four core grants, then bg is forced through
    core_req_i = 1'b1; core_addr_i = 32'h8000_0300;
    bg_req_i = 1'b1; bg_addr_i = 32'h2000_00C0; lsu_req_done_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("starve_g%0d_core", i), 64'(core_req_done_o), 64'd1);
      chk($sformatf("starve_g%0d_bg", i), 64'(bg_req_done_o), 64'd0);
      tick();
      lsu_resp_valid_i = 1'b1; lsu_resp_last_i = 1'b1;
    end
    #1;
    chk("starve_g5_bg", 64'(bg_req_done_o), 64'd1);
    chk("starve_g5_core", 64'(core_req_done_o), 64'd0);
    chk("starve_g5_addr", 64'(lsu_addr_o), 64'h2000_00C0);
    tick();
    chk("starve_g6_core", 64'(core_req_done_o), 64'd1);
    tick();
    core_req_i = 1'b0; bg_req_i = 1'b0; lsu_req_done_i = 1'b0; #1;
    chk("starve_drain", 64'(core_resp_valid_o), 64'd1);
    tick();
    lsu_resp_valid_i = 1'b0; lsu_resp_last_i = 1'b0;

    // reset during a locked bg request, with one entry outstanding
    core_req_i = 1'b1; core_addr_i = 32'h8000_0400; lsu_req_done_i = 1'b1;
    tick();
    core_req_i = 1'b0; lsu_req_done_i = 1'b0;
    bg_req_i = 1'b1; bg_we_i = 1'b1; bg_addr_i = 32'h2000_0100; #1;
    chk("rl_bg_req", 64'(lsu_req_o), 64'd1);
    tick();
    core_req_i = 1'b1; core_addr_i = 32'h8000_0500; rst_ni = 1'b0; #1;
    chk("rl_lsu_req", 64'(lsu_req_o), 64'd0);
    chk("rl_lsu_addr", 64'(lsu_addr_o), 64'd0);
    chk("rl_bg_done", 64'(bg_req_done_o), 64'd0);
    chk("rl_snoop_req", 64'(snoop_req_o), 64'd0);
    chk("rl_snoop_addr", 64'(snoop_addr_o), 64'd0);
    tick();
    bg_req_i = 1'b0; rst_ni = 1'b1; #1;
    chk("post_rst_req", 64'(lsu_req_o), 64'd1);
    chk("post_rst_addr", 64'(lsu_addr_o), 64'h8000_0500);
    lsu_req_done_i = 1'b1; #1;
    chk("post_rst_done", 64'(core_req_done_o), 64'd1);
    tick();
    chk("post_rst_fifo_cleared", 64'(fifo_full_o), 64'd0);
    tick();
    core_req_i = 1'b0; lsu_req_done_i = 1'b0; #1;
    chk("post_rst_full", 64'(fifo_full_o), 64'd1);
    lsu_resp_valid_i = 1'b1; lsu_resp_last_i = 1'b1; #1;
    chk("post_rst_resp", 64'(core_resp_valid_o), 64'd1);
    tick();
    tick();
    lsu_resp_valid_i = 1'b0; lsu_resp_last_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cheri_lsu_bg_arb.md
Name: cheri_lsu_bg_arb

Overview:
- Arbitrates the shared load/store unit (LSU) request port between the core pipeline and the background-engine port. The background port is the merged TBRE/stack-zeroing request stream.
- Routes LSU completions and responses back to the owner of each transaction.
- Drives the snoop interface and the response-side signals consumed by the background engines.
- Sits between the background-engine wrapper and the LSU datapath.

Parameters:
- OutstDepth, 2, maximum number of LSU transactions with a response still pending; depth of the owner-tag FIFO (power of 2, at least 2).
- BgStarveMax, 4, consecutive core grants allowed while a background request is waiting before the background port is forced through (1..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core request valid
- core_we_i  in  1  core write
- core_is_cap_i  in  1  core capability (two-word) access
- core_addr_i  in  32  core address
- core_wdata_i  in  33  core write data (tag plus word)
- core_req_done_o  out  1  core request accepted
- core_resp_valid_o  out  1  core response valid
- bg_req_i  in  1  background request valid
- bg_we_i  in  1  background write
- bg_is_cap_i  in  1  background capability access
- bg_addr_i  in  32  background address
- bg_wdata_i  in  33  background write data
- bg_req_done_o  out  1  background request accepted
- bg_resp_valid_o  out  1  background response valid
- bg_resp_err_o  out  1  background response error
- bg_resp_is_wr_o  out  1  background response belongs to a write
- lsu_req_o  out  1  LSU request
- lsu_we_o  out  1  LSU write
- lsu_is_cap_o  out  1  LSU capability access
- lsu_addr_o  out  32  LSU address
- lsu_wdata_o  out  33  LSU write data
- lsu_req_done_i  in  1  LSU accepted the whole transaction (all beats)
- lsu_resp_valid_i  in  1  response beat valid
- lsu_resp_last_i  in  1  final response beat of a transaction
- lsu_resp_err_i  in  1  response error
- snoop_req_o  out  1  snoop: core request
- snoop_req_done_o  out  1  snoop: core request accepted
- snoop_we_o  out  1  snoop: core write
- snoop_is_cap_o  out  1  snoop: core capability access
- snoop_addr_o  out  32  snoop: core address
- fifo_full_o  out  1  owner FIFO full (debug/status)

Behaviour:
- Reset:
  - All outputs are 0.
  - Owner FIFO is empty; the starvation counter is 0; the lock is cleared.
  - Reset mid-transaction discards all pending ownership; responses arriving after reset are ignored until a new grant.
- Arbitration is combinational when unlocked:
  - The core wins unless the starvation counter has reached BgStarveMax and bg_req_i=1.
  - The winner's request, we, is_cap, addr and wdata drive the lsu_* outputs.
  - lsu_req_o = winner request AND NOT fifo_full.
- Lock:
  - If lsu_req_o=1 and lsu_req_done_i=0, the owner is registered.
  - The mux stays on the registered owner until lsu_req_done_i, so the address and data held by the requester stay stable.
  - A higher-priority request arriving during the lock is not granted until the lock releases.
- Done routing: core_req_done_o and bg_req_done_o are lsu_req_done_i gated by the current owner. The done is combinational, zero cycles after lsu_req_done_i.
- On lsu_req_done_i, push {owner, we} into the owner FIFO.
- Response routing:
  - The head of the FIFO selects the destination of lsu_resp_valid_i. Routing is combinational.
  - bg_resp_err_o and bg_resp_is_wr_o are qualified by bg_resp_valid_o.
  - Pop on lsu_resp_valid_i & lsu_resp_last_i.
  - A push and a pop in the same cycle leave the count unchanged.
  - A response with the FIFO empty is dropped, and an assertion fires.
- Full/empty: fifo_full_o=1 when count==OutstDepth. While full, lsu_req_o=0; an already-locked request is held, not aborted.
- Starvation counter (4 bits, saturating at BgStarveMax):
  - Increments on each core done while bg_req_i=1.
  - Clears on a bg done, or when bg_req_i=0.
- Snoop outputs:
  - snoop_req_o, we, is_cap and addr are the core_* inputs unqualified.
  - snoop_req_done_o = core_req_done_o.
- Simultaneous arrival of core and bg requests in the same cycle: the core wins unless starvation is forced.

Test Plan:
- Core-only: a core read to 0x8000_0010 with done one cycle later → lsu_addr_o=0x8000_0010, core_req_done_o=1 the same cycle as done; a response with last → core_resp_valid_o=1 and bg_resp_valid_o=0.
- Delayed done: a bg write to 0x2000_0040 is locked for 3 cycles; the core raises a request in cycle 1 → lsu_addr_o stays 0x2000_0040 until done, then switches to the core address.
- Starvation: core requests every cycle and bg_req_i held at 1, BgStarveMax=4 → the 5th grant goes to bg; the counter returns to 0.
- Outstanding limit: OutstDepth=2, two dones with no responses → fifo_full_o=1 and lsu_req_o=0; one last-beat response → lsu_req_o reasserts the next evaluation.
- Response ordering: core done, then bg done, then two last responses, the second with lsu_resp_err_i=1 → the first goes to core; the second goes to bg with bg_resp_err_o=1 and bg_resp_is_wr_o equal to the bg request's we.
- Reset mid-lock: assert rst_ni=0 during a locked bg request → all outputs 0 and the FIFO empty; after reset, a core request is granted immediately.
